// File: rtl/tx_frame_fifo.sv
// Frame-oriented transmit FIFO: bytes become readable only once their whole frame has been committed.
// Overflowed or restarted partial frames are rewound away before the reader can ever see them.
module tx_frame_fifo #(
    parameter int FIFO_DEPTH = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    input  logic       data_in_start,
    input  logic       data_in_end,
    output logic       data_in_ready,
    output logic       frame_dropped,
    output logic [7:0] data_out,
    output logic       data_out_start,
    output logic       data_out_end,
    input  logic       data_out_enable,
    output logic       data_available,
    output logic [1:0] write_state
);
    localparam int ENTRIES = 2 ** FIFO_DEPTH;
    localparam int PW      = FIFO_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DISCARD  = 2'd2
    } wr_state_t;

    wr_state_t     state, state_next;
    logic [PW-1:0] wr_ptr, rd_ptr, frame_base;
    logic [PW-1:0] wr_ptr_next, frame_base_next;
    logic [PW-1:0] wr_addr;
    logic [PW-1:0] frame_count;
    logic [PW-1:0] fill;
    logic [9:0]    mem [ENTRIES];
    logic [9:0]    head;
    logic          full, mem_we, commit, drop, pop, pop_end;

    // Handshake: a byte is consumed on any clock edge where data_in_valid and data_in_ready are both 1.
    // A pop happens on any edge where data_out_enable and data_available are both 1.
    assign fill          = wr_ptr - rd_ptr;
    assign full          = (fill == PW'(ENTRIES));
    assign data_in_ready = !full || (state == DISCARD);
    assign frame_dropped = drop;
    assign write_state   = state;

    always_comb begin
        state_next      = state;
        wr_ptr_next     = wr_ptr;
        frame_base_next = frame_base;
        wr_addr         = wr_ptr;
        mem_we          = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        case (state)
            IDLE: begin
                if (data_in_valid && data_in_start && !full) begin
                    frame_base_next = wr_ptr;
                    mem_we          = 1'b1;
                    wr_ptr_next     = wr_ptr + 1'b1;
                    if (data_in_end) commit = 1'b1;
                    else             state_next = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (data_in_valid) begin
                    if (full) begin
                        // Rewind frees the partial frame's space straight away.
                        wr_ptr_next = frame_base;
                        drop        = 1'b1;
                        state_next  = DISCARD;
                    end else if (data_in_start) begin
                        drop        = 1'b1;
                        wr_addr     = frame_base;
                        mem_we      = 1'b1;
                        wr_ptr_next = frame_base + 1'b1;
                        if (data_in_end) begin
                            commit     = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + 1'b1;
                        if (data_in_end) begin
                            commit     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (data_in_valid) begin
                    if (data_in_start) begin
                        frame_base_next = wr_ptr;
                        if (full) begin
                            // Committed frames fill every entry: the new frame cannot be held either.
                            drop       = 1'b1;
                            state_next = data_in_end ? IDLE : DISCARD;
                        end else begin
                            mem_we      = 1'b1;
                            wr_ptr_next = wr_ptr + 1'b1;
                            if (data_in_end) begin
                                commit     = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = IN_FRAME;
                            end
                        end
                    end else if (data_in_end) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign head           = mem[rd_ptr[FIFO_DEPTH-1:0]];
    assign data_available = (frame_count != '0);
    assign data_out       = data_available ? head[7:0] : 8'h00;
    assign data_out_start = data_available & head[8];
    assign data_out_end   = data_available & head[9];
    assign pop            = data_out_enable && data_available;
    assign pop_end        = pop && head[9];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_base  <= '0;
            frame_count <= '0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            frame_base <= frame_base_next;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // Commit and end-of-frame pop on the same edge cancel out.
            if (commit && !pop_end)      frame_count <= frame_count + 1'b1;
            else if (!commit && pop_end) frame_count <= frame_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[wr_addr[FIFO_DEPTH-1:0]] <= {data_in_end, data_in_start, data_in};
    end

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed bench for tx_frame_fifo: stimulus pushes surviving frame bytes into exp_q,
// a negedge monitor pops and compares every byte the reader consumes.
module tb_tx_frame_fifo;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_start = 1'b0;
    logic       data_in_end = 1'b0;
    logic       data_in_ready;
    logic       frame_dropped;
    logic [7:0] data_out;
    logic       data_out_start;
    logic       data_out_end;
    logic       data_out_enable = 1'b0;
    logic       data_available;
    logic [1:0] write_state;

    logic [9:0] exp_q[$];
    int total = 0;
    int bad = 0;

    tx_frame_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_start(data_in_start),
        .data_in_end(data_in_end),
        .data_in_ready(data_in_ready),
        .frame_dropped(frame_dropped),
        .data_out(data_out),
        .data_out_start(data_out_start),
        .data_out_end(data_out_end),
        .data_out_enable(data_out_enable),
        .data_available(data_available),
        .write_state(write_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clock);
            if (data_available === 1'b0) begin
                check("idle_head_zero", {22'd0, data_out_end, data_out_start, data_out}, 32'd0);
            end else if (data_available === 1'b1 && data_out_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got 0x%0h with empty queue at %0t",
                             {data_out_end, data_out_start, data_out}, $time);
                end else begin
                    check("pop_entry", {22'd0, data_out_end, data_out_start, data_out},
                          {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // driver tasks
    task automatic write_byte(input logic [7:0] d, input logic s, input logic e, output logic dropped);
        int cyc;
        logic rdy;
        data_in       = d;
        data_in_start = s;
        data_in_end   = e;
        data_in_valid = 1'b1;
        dropped = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clock);
            rdy = data_in_ready;
            if (frame_dropped === 1'b1) dropped = 1'b1;
            @(posedge clock);
            #1;
            if (rdy === 1'b1) break;
            cyc++;
            if (cyc > 50) begin
                total++;
                bad++;
                $display("FAIL write_timeout: byte 0x%0h never accepted, expected acceptance", d);
                break;
            end
        end
    endtask

    task automatic bus_idle();
        data_in_valid = 1'b0;
        data_in_start = 1'b0;
        data_in_end   = 1'b0;
    endtask

    task automatic wait_q(input int n, input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() > n) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cyc > 300) begin
                total++;
                bad++;
                $display("FAIL %s: queue size %0d, expected <= %0d", name, exp_q.size(), n);
                break;
            end
        end
    endtask

    initial begin
        logic d;
        int drops;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_ready", data_in_ready, 1);
        check("rst_avail", data_available, 0);
        check("rst_dout", {22'd0, data_out_end, data_out_start, data_out}, 0);
        check("rst_dropped", frame_dropped, 0);
        check("rst_state", write_state, 0);

        // 1: single 4-byte frame
        write_byte(8'h11, 1, 0, d);
        write_byte(8'h22, 0, 0, d);
        write_byte(8'h33, 0, 0, d);
        check("t1_avail_before_end", data_available, 0);
        write_byte(8'h44, 0, 1, d);
        bus_idle();
        check("t1_avail_after_end", data_available, 1);
        exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b00, 8'h33});
        exp_q.push_back({2'b10, 8'h44});
        data_out_enable = 1'b1;
        wait_q(0, "t1_drain");
        check("t1_avail_after_pops", data_available, 0);
        data_out_enable = 1'b0;

        // 2: 3-byte frame then 1-byte frame
        write_byte(8'hA1, 1, 0, d);
        write_byte(8'hA2, 0, 0, d);
        write_byte(8'hA3, 0, 1, d);
        write_byte(8'hB1, 1, 1, d);
        bus_idle();
        check("t2_avail_two", data_available, 1);
        exp_q.push_back({2'b01, 8'hA1});
        exp_q.push_back({2'b00, 8'hA2});
        exp_q.push_back({2'b10, 8'hA3});
        exp_q.push_back({2'b11, 8'hB1});
        data_out_enable = 1'b1;
        wait_q(1, "t2_first");
        check("t2_avail_one", data_available, 1);
        wait_q(0, "t2_second");
        check("t2_avail_zero", data_available, 0);
        data_out_enable = 1'b0;

        // 3: 20-byte frame overflows a 16-entry store
        for (int k = 1; k <= 20; k++) begin
            write_byte(8'(k), k == 1, k == 20, d);
            check($sformatf("t3_drop_b%0d", k), d, k == 17);
        end
        bus_idle();
        check("t3_avail", data_available, 0);
        check("t3_state", write_state, 0);
        write_byte(8'hC1, 1, 0, d);
        write_byte(8'hC2, 0, 1, d);
        bus_idle();
        exp_q.push_back({2'b01, 8'hC1});
        exp_q.push_back({2'b10, 8'hC2});
        data_out_enable = 1'b1;
        wait_q(0, "t3_drain");
        check("t3_avail_end", data_available, 0);
        data_out_enable = 1'b0;

        // 4: restart drops the open frame
        drops = 0;
        write_byte(8'h01, 1, 0, d); drops += int'(d);
        write_byte(8'h02, 0, 0, d); drops += int'(d);
        write_byte(8'h03, 0, 0, d); drops += int'(d);
        write_byte(8'hAA, 1, 0, d); drops += int'(d);
        write_byte(8'hBB, 0, 1, d); drops += int'(d);
        bus_idle();
        check("t4_drop_count", drops, 1);
        exp_q.push_back({2'b01, 8'hAA});
        exp_q.push_back({2'b10, 8'hBB});
        data_out_enable = 1'b1;
        wait_q(0, "t4_drain");
        check("t4_avail_end", data_available, 0);
        data_out_enable = 1'b0;

        // 5: commit of B on the edge that pops A's end byte
        write_byte(8'h51, 1, 0, d);
        write_byte(8'h52, 0, 1, d);
        write_byte(8'h61, 1, 0, d);
        write_byte(8'h62, 0, 0, d);
        bus_idle();
        exp_q.push_back({2'b01, 8'h51});
        exp_q.push_back({2'b10, 8'h52});
        exp_q.push_back({2'b01, 8'h61});
        exp_q.push_back({2'b00, 8'h62});
        exp_q.push_back({2'b10, 8'h63});
        data_out_enable = 1'b1;
        @(posedge clock);
        #1;
        write_byte(8'h63, 0, 1, d);
        bus_idle();
        check("t5_avail_same_edge", data_available, 1);
        check("t5_q_left", exp_q.size(), 3);
        wait_q(0, "t5_drain");
        check("t5_avail_end", data_available, 0);
        data_out_enable = 1'b0;

        // 6: reset mid-write with a committed frame stored
        write_byte(8'h71, 1, 0, d);
        write_byte(8'h72, 0, 1, d);
        write_byte(8'h81, 1, 0, d);
        write_byte(8'h82, 0, 0, d);
        bus_idle();
        check("t6_avail_pre", data_available, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_avail_post", data_available, 0);
        check("t6_ready_post", data_in_ready, 1);
        check("t6_state_post", write_state, 0);
        write_byte(8'h91, 1, 0, d);
        write_byte(8'h92, 0, 0, d);
        write_byte(8'h93, 0, 1, d);
        bus_idle();
        exp_q.push_back({2'b01, 8'h91});
        exp_q.push_back({2'b00, 8'h92});
        exp_q.push_back({2'b10, 8'h93});
        data_out_enable = 1'b1;
        wait_q(0, "t6_drain");
        check("t6_avail_end", data_available, 0);
        data_out_enable = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
